alu_seq_exec: RTL and testbench

Sequential execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation on two XLEN-bit operands. It sits in the execute stage and accepts one request at a time over a valid/ready handshake. Shifts run iteratively at one bit per cycle by default, and all other operations complete in one cycle. Results are held on a valid/ready response port until the consumer accepts them.

---
 rtl/alu_seq_exec.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq_exec.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// Sequential execute unit: one request at a time, valid/ready on both sides.
// Build option: define ALU_BARREL_SHIFT_EN for single-cycle combinational shifts.
//
// state | meaning
// IDLE  | ready for a request; operands captured on acceptance
// SHIFT | iterative shift, one bit per cycle (absent with ALU_BARREL_SHIFT_EN)
// DONE  | result held until the consumer takes it
module alu_seq_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      alu_control_op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_op_o
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;

  logic            accept;
  logic            illegal_op;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;

  assign accept     = req_valid_i && req_ready_o;
  assign illegal_op = alu_control_op_i[3];
  assign shamt      = operand_b_i[SHW-1:0];

`ifndef ALU_BARREL_SHIFT_EN
  logic            is_shift;
  logic            start_shift;
  logic [XLEN-1:0] shreg_q;
  logic [XLEN-1:0] shreg_step;
  logic [SHW-1:0]  cnt_q;
  logic [1:0]      shop_q;

  assign is_shift    = (alu_control_op_i == OP_SLL) || (alu_control_op_i == OP_SRL) ||
                       (alu_control_op_i == OP_SRA);
  assign start_shift = accept && is_shift && (shamt != '0);

  // shop_q holds op[1:0]: 00 sll, 01 srl, 11 sra
  always_comb begin
    shreg_step = shreg_q;
    case (shop_q)
      2'b00:   shreg_step = shreg_q << 1;
      2'b01:   shreg_step = shreg_q >> 1;
      default: shreg_step = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
    endcase
  end
`endif

  // In the iterative build a shift reaching here has shamt==0, so it passes operand_a.
  always_comb begin
    alu_res = '0;
    case (alu_control_op_i)
      OP_AND: alu_res = operand_a_i & operand_b_i;
      OP_OR:  alu_res = operand_a_i | operand_b_i;
      OP_ADD: alu_res = operand_a_i + operand_b_i;
      OP_XOR: alu_res = operand_a_i ^ operand_b_i;
      OP_SUB: alu_res = operand_a_i - operand_b_i;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL: alu_res = operand_a_i << shamt;
      OP_SRL: alu_res = operand_a_i >> shamt;
      OP_SRA: alu_res = XLEN'($signed(operand_a_i) >>> shamt);
`else
      OP_SLL: alu_res = operand_a_i;
      OP_SRL: alu_res = operand_a_i;
      OP_SRA: alu_res = operand_a_i;
`endif
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
          if (start_shift) state_d = S_SHIFT;
          else
`endif
          state_d = S_DONE;
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      S_SHIFT: begin
        if (cnt_q == SHW'(1)) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    resp_valid_o = (state_q == S_DONE);
  end

  // The last shift step lands directly in result_q so DONE follows the final decrement.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      shreg_q   <= '0;
      cnt_q     <= '0;
      shop_q    <= 2'b00;
`endif
    end else begin
      if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
        if (start_shift) begin
          shreg_q   <= operand_a_i;
          cnt_q     <= shamt;
          shop_q    <= alu_control_op_i[1:0];
          illegal_q <= 1'b0;
        end else
`endif
        begin
          result_q  <= alu_res;
          illegal_q <= illegal_op;
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      if (state_q == S_SHIFT) begin
        shreg_q <= shreg_step;
        cnt_q   <= cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) result_q <= shreg_step;
      end
`endif
    end
  end

  assign result_o     = result_q;
  assign illegal_op_o = illegal_q;
  assign zero_o       = (result_q == '0);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: expectations queued at acceptance, checked at response handshake.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int first_cyc = 0;
  int hs_cyc = 0;
  bit seen = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  alu_seq_exec #(.XLEN(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .alu_control_op_i (op),
    .operand_a_i      (a),
    .operand_b_i      (b),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .result_o         (result),
    .zero_o           (zero),
    .illegal_op_o     (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int shift_lat(input int s);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    return 1 + s;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    logic signed [31:0] sa;
    sa = av;
    case (o)
      4'd0: return av & bv;
      4'd1: return av | bv;
      4'd2: return av + bv;
      4'd3: return av ^ bv;
      4'd4: return av << bv[4:0];
      4'd5: return av >> bv[4:0];
      4'd6: return av - bv;
      4'd7: return sa >>> bv[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (resp_valid && !seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (resp_valid && resp_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e_mon = sb.pop_front();
          check("result", result, e_mon.res);
          check("zero", 32'(zero), 32'(e_mon.res == 32'd0));
          check("illegal", 32'(illegal), 32'(e_mon.ill));
          check("latency", 32'(first_cyc - acc_cyc), 32'(e_mon.lat));
        end
        seen = 1'b0;
        hs_cyc = cyc;
      end
    end
  end

  task automatic do_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic ei, input int el, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk);
    #1;
    op = o;
    a = av;
    b = bv;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    if (push) begin
      e.res = er;
      e.ill = ei;
      e.lat = el;
      sb.push_back(e);
    end
    #1;
    req_valid = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || resp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int vcount;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    int r;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_op(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1, 1'b1);
    drain();
    do_op(4'd6, 32'd5, 32'd5, 32'd0, 1'b0, 1, 1'b1);
    drain();
    do_op(4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, shift_lat(4), 1'b1);
    drain();
    do_op(4'd5, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, shift_lat(4), 1'b1);
    drain();
    do_op(4'd4, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1, 1'b1);
    drain();
    do_op(4'd4, 32'h1234_5678, 32'h0000_0021, 32'h2468_ACF0, 1'b0, shift_lat(1), 1'b1);
    drain();
    do_op(4'b1010, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b1, 1, 1'b1);
    drain();
    do_op(4'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1, 1'b1);
    drain();

    // backpressure with a second request held at the input
    @(posedge clk);
    #1 resp_ready = 1'b0;
    do_op(4'd3, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1, 1'b1);
    op = 4'd1;
    a = 32'h0000_00F0;
    b = 32'h0000_000F;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) begin
      @(negedge clk);
      check("bp_result", result, 32'h5A5A_5A5A);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(resp_valid), 32'd1);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    do_op(4'd1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1, 1'b1);
    check("bp_next_accept", 32'(acc_cyc), 32'(hs_cyc + 1));
    drain();

    for (int i = 0; i < 24; i++) begin
      r  = int'($urandom_range(0, 9));
      ro = (r < 8) ? 4'(r) : (4'b1000 | 4'($urandom_range(0, 7)));
      ra = $urandom;
      rb = $urandom;
      do_op(ro, ra, rb, model(ro, ra, rb), ro[3],
            (ro == 4'd4 || ro == 4'd5 || ro == 4'd7) ? shift_lat(int'(rb[4:0])) : 1, 1'b1);
    end
    drain();

    // reset in the middle of a long shift drops the operation
    do_op(4'd4, 32'h0000_0001, 32'd31, 32'd0, 1'b0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) vcount++;
    end
    check("mid_rst_no_resp", 32'(vcount), 32'd0);

    do_op(4'd2, 32'd3, 32'd4, 32'd7, 1'b0, 1, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
